dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Two-master arbiter in front of data_memory (256 x 16-bit, sync write, sync read).
//  Shares the single memory port between m0 (CPU load/store) and m1 (DMA/debug loader).
//  Bounds bursts so neither master starves, and returns read data one cycle after grant,
//  routed to the master that issued the read.
// PARAMETERS
//  MAX_BURST  4  max consecutive granted beats for one owner while the other master requests (>=1)
//  CNT_W      3  beat-counter width; must satisfy 2**CNT_W > MAX_BURST
// PORTS
//  clk             in   1            system clock; all state on posedge
//  rst_n           in   1            asynchronous, active-low reset
//  m0_req/m1_req   in   1            master requests a beat this cycle
//  m0_we/m1_we     in   1            1 = write beat, 0 = read beat
//  m0_addr/m1_addr in   WORD_WIDTH   word address, passed through unmodified
//  m0_wdata/m1_wdata in WORD_WIDTH   write data
//  m0_gnt/m1_gnt   out  1            beat accepted at the coming posedge (combinational)
//  m0_rvalid/m1_rvalid out 1         read data valid (registered, 1 cycle after granted read)
//  m0_rdata/m1_rdata out WORD_WIDTH  = mem_read_data; meaningful only while rvalid is high
//  mem_addr        out  WORD_WIDTH   address to data_memory
//  mem_write_data  out  WORD_WIDTH   write data to data_memory
//  mem_write_en    out  1            = gnt & we of the winner
//  mem_read_en     out  1            = gnt & !we of the winner
//  mem_read_data   in   WORD_WIDTH   data_memory read_data (valid the cycle after mem_read_en)
// BEHAVIOUR
//  - FSM state = current owner: IDLE, OWN0, OWN1. cnt = beats granted to the current owner.
//  - IDLE: no requests -> no grant. One request -> that master. Both -> priority rule (CONFIGURATION).
//    On grant: next state OWNx, cnt <= 1.
//  - OWNx, owner requesting, and (cnt < MAX_BURST or other idle): grant owner, cnt <= sat(cnt+1).
//  - OWNx, other requesting, and (owner idle or cnt == MAX_BURST): grant other,
//    next OWN_other, cnt <= 1.
//  - OWNx, no requests: no grant, next IDLE, cnt <= 0.
//  - At most one gnt per cycle. A beat completes at the posedge where req&gnt are both high.
//    A master holds addr/we/wdata stable until granted.
//  - Read latency: exactly 1 cycle. Granted read in cycle N -> mX_rvalid=1 in cycle N+1 only.
//    Back-to-back reads are allowed, including alternating owners; each rvalid goes to its issuer.
//  - Writes produce no response. The write takes effect at the grant posedge.
//  - Ungranted cycle: mem_write_en = mem_read_en = 0; mem_addr/mem_write_data follow m0.
//  - Reset (async assert; release sync to clk): state IDLE, cnt 0, last_owner 1, rvalid 0.
//    While rst_n = 0: gnt and mem enables forced to 0.
//    Reset in the cycle after a granted read drops the response (no rvalid).
//  - MAX_BURST = 1: strict alternation under continuous contention.
//  - Address aliasing (addr >= DATA_MEM_DEPTH) is the memory's concern; no range check here.
// CONFIGURATION
//  DMEM_ARB_RR_EN defined: IDLE contention goes to !last_owner.
//    last_owner updates on every grant; reset value 1, so m0 wins first.
//  Undefined: IDLE contention always goes to m0 (CPU fixed priority).
//    The burst limit still applies in both modes.
// STRUCTURE
//  defines.vh: WORD_WIDTH, DATA_MEM_DEPTH, DATA_MEM_ADDR_WIDTH, plus new owner encodings
//    ARB_IDLE=2'd0, ARB_OWN0=2'd1, ARB_OWN1=2'd2.
//  Single flat module; no sub-module. Winner select, FSM, counter and response tags all live here.
//  Instantiated between cpu_top/DMA and data_memory.
// TESTING
//  1 rst_n=0, m0_req=m1_req=1 -> m0_gnt=m1_gnt=0, mem_write_en=mem_read_en=0, rvalid=0.
//  2 m0 write 0xBEEF @0x0010, then m0 read @0x0010 -> gnt same cycle;
//    next cycle m0_rvalid=1, m0_rdata=0xBEEF, m1_rvalid=0.
//  3 IDLE, both req every cycle, MAX_BURST=4 -> grants 0,0,0,0,1,1,1,1,0...
//    With RR_EN, start from last_owner=0 -> first grant m1.
//  4 m1 holds req; m0 raises req after m1's 2nd beat -> m1 gets beats 3,4, then m0 granted on cycle 5.
//  5 Alternating reads m0@0x01, m1@0x02, m0@0x03 (data 0xA1/0xA2/0xA3) -> rvalid pulses on
//    m0, m1, m0 in consecutive cycles with matching data.
//  6 Granted m1 read, rst_n pulsed low next cycle -> m1_rvalid stays 0; after release, state IDLE.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared types and sizes for the data-memory arbiter: word/memory geometry,
// owner encodings and the per-beat memory request payload.
package dmem_arbiter_pkg;

  localparam int unsigned WORD_WIDTH          = 16;
  localparam int unsigned DATA_MEM_DEPTH      = 256;
  localparam int unsigned DATA_MEM_ADDR_WIDTH = 8;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_OWN0 = 2'd1,
    ARB_OWN1 = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic                  we;
    logic [WORD_WIDTH-1:0] addr;
    logic [WORD_WIDTH-1:0] wdata;
  } mem_beat_t;

endpackage

// File: rtl/dmem_arbiter.sv
// Two-master burst-bounded arbiter in front of data_memory; read data is tagged back to its issuer.
// Define DMEM_ARB_RR_EN for round-robin idle contention; otherwise m0 (CPU) has fixed priority.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned MAX_BURST = 4,
  parameter int unsigned CNT_W     = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [WORD_WIDTH-1:0] m0_addr,
  input  logic [WORD_WIDTH-1:0] m0_wdata,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [WORD_WIDTH-1:0] m1_addr,
  input  logic [WORD_WIDTH-1:0] m1_wdata,
  output logic                  m0_gnt,
  output logic                  m1_gnt,
  output logic                  m0_rvalid,
  output logic                  m1_rvalid,
  output logic [WORD_WIDTH-1:0] m0_rdata,
  output logic [WORD_WIDTH-1:0] m1_rdata,
  output logic [WORD_WIDTH-1:0] mem_addr,
  output logic [WORD_WIDTH-1:0] mem_write_data,
  output logic                  mem_write_en,
  output logic                  mem_read_en,
  input  logic [WORD_WIDTH-1:0] mem_read_data
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

  arb_state_e       r_state;
  arb_state_e       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_burst_left;
  logic             w_idle_pick1;
  logic             w_gnt0;
  logic             w_gnt1;
  logic             r_m0_rvalid;
  logic             r_m1_rvalid;
  mem_beat_t        w_beat;

`ifdef DMEM_ARB_RR_EN
  logic r_last_owner;
  assign w_idle_pick1 = ~r_last_owner;
`else
  assign w_idle_pick1 = 1'b0;
`endif

  // Counter saturates at the burst limit so a long solo burst still yields immediately.
  assign w_burst_left = (r_cnt < MAX_CNT);
  assign w_cnt_inc    = w_burst_left ? (r_cnt + ONE_CNT) : MAX_CNT;

  // Next owner, grants and beat count
  always_comb begin
    w_gnt0      = 1'b0;
    w_gnt1      = 1'b0;
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ARB_OWN0: begin
        if (m0_req && (w_burst_left || !m1_req)) begin
          w_gnt0    = 1'b1;
          w_cnt_nxt = w_cnt_inc;
        end else if (m1_req) begin
          w_gnt1      = 1'b1;
          w_state_nxt = ARB_OWN1;
          w_cnt_nxt   = ONE_CNT;
        end else begin
          w_state_nxt = ARB_IDLE;
          w_cnt_nxt   = '0;
        end
      end
      ARB_OWN1: begin
        if (m1_req && (w_burst_left || !m0_req)) begin
          w_gnt1    = 1'b1;
          w_cnt_nxt = w_cnt_inc;
        end else if (m0_req) begin
          w_gnt0      = 1'b1;
          w_state_nxt = ARB_OWN0;
          w_cnt_nxt   = ONE_CNT;
        end else begin
          w_state_nxt = ARB_IDLE;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        if (m0_req && (!m1_req || !w_idle_pick1)) begin
          w_gnt0      = 1'b1;
          w_state_nxt = ARB_OWN0;
          w_cnt_nxt   = ONE_CNT;
        end else if (m1_req) begin
          w_gnt1      = 1'b1;
          w_state_nxt = ARB_OWN1;
          w_cnt_nxt   = ONE_CNT;
        end else begin
          w_state_nxt = ARB_IDLE;
          w_cnt_nxt   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ARB_IDLE;
      r_cnt       <= '0;
      r_m0_rvalid <= 1'b0;
      r_m1_rvalid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_m0_rvalid <= w_gnt0 & ~m0_we;
      r_m1_rvalid <= w_gnt1 & ~m1_we;
    end
  end

`ifdef DMEM_ARB_RR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_owner <= 1'b1;
    end else if (w_gnt0) begin
      r_last_owner <= 1'b0;
    end else if (w_gnt1) begin
      r_last_owner <= 1'b1;
    end
  end
`endif

  // Memory port follows the winner; m0 when nobody is granted.
  assign w_beat = w_gnt1 ? '{we: m1_we, addr: m1_addr, wdata: m1_wdata}
                         : '{we: m0_we, addr: m0_addr, wdata: m0_wdata};

  assign m0_gnt         = w_gnt0 & rst_n;
  assign m1_gnt         = w_gnt1 & rst_n;
  assign mem_addr       = w_beat.addr;
  assign mem_write_data = w_beat.wdata;
  assign mem_write_en   = (m0_gnt | m1_gnt) & w_beat.we;
  assign mem_read_en    = (m0_gnt | m1_gnt) & ~w_beat.we;

  assign m0_rvalid = r_m0_rvalid;
  assign m1_rvalid = r_m1_rvalid;
  assign m0_rdata  = mem_read_data;
  assign m1_rdata  = mem_read_data;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Table-driven bench for dmem_arbiter with a read-response scoreboard and a behavioural data_memory.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [15:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [15:0] m0_rdata, m1_rdata, mem_addr, mem_write_data, mem_read_data;
  logic        mem_write_en, mem_read_en;

  int n_err = 0;
  int n_checks = 0;

  typedef struct {
    logic        req0, we0;
    logic [15:0] a0, d0;
    logic        req1, we1;
    logic [15:0] a1, d1;
    logic        g0, g1;
  } vec_t;

  typedef struct {
    logic        m;
    logic [15:0] data;
  } resp_t;

  vec_t        vecs[$];
  resp_t       sb[$];
  logic [15:0] env_mem [256];
  logic [15:0] ref_mem [256];

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
    .m0_rdata(m0_rdata), .m1_rdata(m1_rdata), .mem_addr(mem_addr),
    .mem_write_data(mem_write_data), .mem_write_en(mem_write_en),
    .mem_read_en(mem_read_en), .mem_read_data(mem_read_data)
  );

  // data_memory stand-in: sync write, sync read
  always @(posedge clk) begin
    if (mem_write_en) env_mem[mem_addr[7:0]] <= mem_write_data;
    if (mem_read_en)  mem_read_data <= env_mem[mem_addr[7:0]];
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic req0, input logic we0, input logic [15:0] a0,
                              input logic [15:0] d0, input logic req1, input logic we1,
                              input logic [15:0] a1, input logic [15:0] d1,
                              input logic g0, input logic g1);
    vec_t v;
    v.req0 = req0; v.we0 = we0; v.a0 = a0; v.d0 = d0;
    v.req1 = req1; v.we1 = we1; v.a1 = a1; v.d1 = d1;
    v.g0 = g0; v.g1 = g1;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    m0_req = v.req0; m0_we = v.we0; m0_addr = v.a0; m0_wdata = v.d0;
    m1_req = v.req1; m1_we = v.we1; m1_addr = v.a1; m1_wdata = v.d1;
  endtask

  task automatic apply(input vec_t v, input string tag);
    resp_t       r;
    logic        e_rv0, e_rv1;
    logic [15:0] a;
    @(negedge clk);
    drive(v);
    #1;
    e_rv0 = 1'b0; e_rv1 = 1'b0;
    r.m = 1'b0; r.data = '0;
    if (sb.size() > 0) begin
      r = sb.pop_front();
      e_rv0 = (r.m == 1'b0);
      e_rv1 = (r.m == 1'b1);
    end
    chk({tag, " m0_gnt"}, 16'(m0_gnt), 16'(v.g0));
    chk({tag, " m1_gnt"}, 16'(m1_gnt), 16'(v.g1));
    chk({tag, " m0_rvalid"}, 16'(m0_rvalid), 16'(e_rv0));
    chk({tag, " m1_rvalid"}, 16'(m1_rvalid), 16'(e_rv1));
    if (e_rv0) chk({tag, " m0_rdata"}, m0_rdata, r.data);
    if (e_rv1) chk({tag, " m1_rdata"}, m1_rdata, r.data);
    chk({tag, " mem_write_en"}, 16'(mem_write_en), 16'((v.g0 & v.we0) | (v.g1 & v.we1)));
    chk({tag, " mem_read_en"}, 16'(mem_read_en), 16'((v.g0 & ~v.we0) | (v.g1 & ~v.we1)));
    a = v.g1 ? v.a1 : v.a0;
    chk({tag, " mem_addr"}, mem_addr, a);
    if ((v.g0 && v.we0) || (v.g1 && v.we1)) begin
      chk({tag, " mem_write_data"}, mem_write_data, v.g1 ? v.d1 : v.d0);
      ref_mem[a[7:0]] = v.g1 ? v.d1 : v.d0;
    end else if (v.g0 || v.g1) begin
      r.m = v.g1;
      r.data = ref_mem[a[7:0]];
      sb.push_back(r);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not end, errors=%0d", n_err);
    $fatal(1);
  end

  initial begin
    vec_t idle;
    for (int i = 0; i < 256; i++) begin
      env_mem[i] = '0;
      ref_mem[i] = '0;
    end
    idle = mk(0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0);

    // reset holds off all grants even under contention
    rst_n = 1'b0;
    drive(mk(1, 1, 16'h0005, 16'h1234, 1, 0, 16'h0006, 16'h0000, 0, 0));
    repeat (2) @(negedge clk);
    #1;
    chk("rst m0_gnt", 16'(m0_gnt), 16'd0);
    chk("rst m1_gnt", 16'(m1_gnt), 16'd0);
    chk("rst mem_write_en", 16'(mem_write_en), 16'd0);
    chk("rst mem_read_en", 16'(mem_read_en), 16'd0);
    chk("rst m0_rvalid", 16'(m0_rvalid), 16'd0);
    chk("rst m1_rvalid", 16'(m1_rvalid), 16'd0);
    @(negedge clk);
    drive(idle);
    rst_n = 1'b1;

    // write then read back on m0
    vecs.push_back(mk(1, 1, 16'h0010, 16'hBEEF, 0, 0, 16'h0000, 16'h0000, 1, 0));
    vecs.push_back(mk(1, 0, 16'h0010, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1, 0));
    vecs.push_back(idle);
    // idle contention after m0 was last owner
`ifdef DMEM_ARB_RR_EN
    vecs.push_back(mk(1, 1, 16'h0020, 16'h1111, 1, 1, 16'h0021, 16'h2222, 0, 1));
`else
    vecs.push_back(mk(1, 1, 16'h0020, 16'h1111, 1, 1, 16'h0021, 16'h2222, 1, 0));
`endif
    vecs.push_back(idle);
    // continuous contention: bursts of four
    for (int k = 0; k < 9; k++)
      vecs.push_back(mk(1, 1, 16'h0001, 16'h00A1, 1, 1, 16'h0002, 16'h00A2,
                        (k < 4) || (k == 8), (k >= 4) && (k < 8)));
    vecs.push_back(mk(1, 1, 16'h0003, 16'h00A3, 0, 0, 16'h0000, 16'h0000, 1, 0));
    vecs.push_back(idle);
    // m1 owns, m0 joins after beat 2: m1 finishes beats 3,4
    vecs.push_back(mk(0, 0, 16'h0000, 16'h0000, 1, 0, 16'h0002, 16'h0000, 0, 1));
    vecs.push_back(mk(0, 0, 16'h0000, 16'h0000, 1, 0, 16'h0002, 16'h0000, 0, 1));
    vecs.push_back(mk(1, 0, 16'h0001, 16'h0000, 1, 0, 16'h0002, 16'h0000, 0, 1));
    vecs.push_back(mk(1, 0, 16'h0001, 16'h0000, 1, 0, 16'h0002, 16'h0000, 0, 1));
    vecs.push_back(mk(1, 0, 16'h0001, 16'h0000, 1, 0, 16'h0002, 16'h0000, 1, 0));
    vecs.push_back(idle);
    // alternating back-to-back reads
    vecs.push_back(mk(1, 0, 16'h0001, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 16'h0000, 1, 0, 16'h0002, 16'h0000, 0, 1));
    vecs.push_back(mk(1, 0, 16'h0003, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1, 0));
    vecs.push_back(idle);
    vecs.push_back(idle);
    // long solo burst saturates the count; m1 gets in at once
    for (int k = 0; k < 6; k++)
      vecs.push_back(mk(1, 0, 16'h0010, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1, 0));
    vecs.push_back(mk(1, 0, 16'h0010, 16'h0000, 1, 0, 16'h0021, 16'h0000, 0, 1));
    vecs.push_back(idle);

    foreach (vecs[i]) apply(vecs[i], $sformatf("v%0d", i));

    // reset right after a granted m1 read drops the response
    apply(mk(0, 0, 16'h0000, 16'h0000, 1, 0, 16'h0002, 16'h0000, 0, 1), "r6 grant");
    @(negedge clk);
    drive(idle);
    rst_n = 1'b0;
    #1;
    chk("r6 m1_rvalid", 16'(m1_rvalid), 16'd0);
    chk("r6 m0_rvalid", 16'(m0_rvalid), 16'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    // back in IDLE: contention goes to m0 in either priority mode
    apply(mk(1, 0, 16'h0001, 16'h0000, 1, 0, 16'h0002, 16'h0000, 1, 0), "r6 idle");
    apply(idle, "r6 tail");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
